// File: rtl/axis_sink_monitor.sv
// AXI4-Stream sink with selectable tready pattern, FWFT capture FIFO,
// beat/packet counters and a sticky protocol-stability error flag.
module axis_sink_monitor #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          DEPTH        = 16,
  parameter int          READY_MODE   = 0,
  parameter int          READY_PERIOD = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tlast,
  input  logic                      rd_en,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [31:0]               beat_cnt,
  output logic [31:0]               pkt_cnt,
  output logic                      err_protocol
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam logic [AW:0]   FULL_FILL   = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] PERIOD_LOAD = PW'(READY_PERIOD - 1);

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  ready_gen;
  logic                  push;
  logic                  pop;
  logic [PW-1:0]         period_cnt;
  logic [15:0]           lfsr;
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  // tready depends only on registered state, so a pop in a full cycle
  // cannot open the door for a push until the next cycle.
  assign full          = (fill == FULL_FILL);
  assign rd_valid      = (fill != '0);
  assign s_axis_tready = ready_gen & ~full & ~areset;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = rd_en & rd_valid;
  assign rd_data       = mem[rd_ptr][DATA_WIDTH-1:0];
  assign rd_last       = mem[rd_ptr][DATA_WIDTH];

  always_comb begin
    ready_gen = 1'b1;
    case (READY_MODE)
      0:       ready_gen = 1'b1;
      1:       ready_gen = (period_cnt == '0);
      default: ready_gen = lfsr[0];
    endcase
  end

  // Down-counter reloads at terminal count; ready is high on the terminal cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      period_cnt <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      period_cnt <= (period_cnt == '0) ? PERIOD_LOAD : period_cnt - 1'b1;
      lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      beat_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        beat_cnt <= beat_cnt + 32'd1;
        if (s_axis_tlast) begin
          pkt_cnt <= pkt_cnt + 32'd1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // A stalled beat must stay valid with unchanged payload on the next cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_protocol <= 1'b0;
      stall_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
    end else begin
      if (stall_q && (!s_axis_tvalid || s_axis_tdata != data_q || s_axis_tlast != last_q)) begin
        err_protocol <= 1'b1;
      end
      stall_q <= s_axis_tvalid & ~s_axis_tready;
      data_q  <= s_axis_tdata;
      last_q  <= s_axis_tlast;
    end
  end

endmodule

// File: tb/tb_axis_sink_monitor.sv
// Bench for axis_sink_monitor: three instances (ready modes 0/1/2) share one
// stimulus; a queue-based model checks every cycle, plus directed sequences.
module tb_axis_sink_monitor;
  localparam int ND    = 3;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] tdata = 8'h00;

  logic        tready   [ND];
  logic        rd_valid [ND];
  logic        rd_last  [ND];
  logic        err      [ND];
  logic [7:0]  rd_data  [ND];
  logic [4:0]  fill     [ND];
  logic [31:0] beat     [ND];
  logic [31:0] pkt      [ND];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_sink_monitor #(.DATA_WIDTH(8), .DEPTH(DEPTH), .READY_MODE(0), .READY_PERIOD(4), .LFSR_SEED(16'hACE1)) dut0 (
    .aclk(clk), .areset(areset), .s_axis_tvalid(tvalid), .s_axis_tready(tready[0]),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .rd_en(rd_en), .rd_valid(rd_valid[0]),
    .rd_data(rd_data[0]), .rd_last(rd_last[0]), .fill(fill[0]), .beat_cnt(beat[0]),
    .pkt_cnt(pkt[0]), .err_protocol(err[0]));

  axis_sink_monitor #(.DATA_WIDTH(8), .DEPTH(DEPTH), .READY_MODE(1), .READY_PERIOD(4), .LFSR_SEED(16'hACE1)) dut1 (
    .aclk(clk), .areset(areset), .s_axis_tvalid(tvalid), .s_axis_tready(tready[1]),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .rd_en(rd_en), .rd_valid(rd_valid[1]),
    .rd_data(rd_data[1]), .rd_last(rd_last[1]), .fill(fill[1]), .beat_cnt(beat[1]),
    .pkt_cnt(pkt[1]), .err_protocol(err[1]));

  axis_sink_monitor #(.DATA_WIDTH(8), .DEPTH(DEPTH), .READY_MODE(2), .READY_PERIOD(4), .LFSR_SEED(16'hACE1)) dut2 (
    .aclk(clk), .areset(areset), .s_axis_tvalid(tvalid), .s_axis_tready(tready[2]),
    .s_axis_tdata(tdata), .s_axis_tlast(tlast), .rd_en(rd_en), .rd_valid(rd_valid[2]),
    .rd_data(rd_data[2]), .rd_last(rd_last[2]), .fill(fill[2]), .beat_cnt(beat[2]),
    .pkt_cnt(pkt[2]), .err_protocol(err[2]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, ready pattern from cycle count / LFSR.
  logic [8:0]  mq     [ND][$];
  int          mcyc   [ND];
  logic [15:0] mlfsr  [ND];
  logic [31:0] mbeat  [ND];
  logic [31:0] mpkt   [ND];
  logic        merr   [ND];
  logic        mpst   [ND];
  logic        mplast [ND];
  logic [7:0]  mpdata [ND];
  bit          started = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic logic model_ready(input int d);
    logic rg;
    case (d)
      0:       rg = 1'b1;
      1:       rg = ((mcyc[d] % 4) == 0);
      default: rg = mlfsr[d][0];
    endcase
    return rg && (mq[d].size() < DEPTH) && !areset;
  endfunction

  initial forever begin
    logic rdy [ND];
    @(posedge clk);
    for (int d = 0; d < ND; d++) rdy[d] = model_ready(d);
    for (int d = 0; d < ND; d++) begin
      if (areset) begin
        mq[d].delete();
        mcyc[d] = 0; mlfsr[d] = 16'hACE1; mbeat[d] = 0; mpkt[d] = 0;
        merr[d] = 1'b0; mpst[d] = 1'b0; mplast[d] = 1'b0; mpdata[d] = 8'h00;
      end else begin
        if (mpst[d] && (!tvalid || tdata != mpdata[d] || tlast != mplast[d])) merr[d] = 1'b1;
        mpst[d] = tvalid && !rdy[d];
        mpdata[d] = tdata;
        mplast[d] = tlast;
        if (rd_en && mq[d].size() > 0) void'(mq[d].pop_front());
        if (tvalid && rdy[d]) begin
          mq[d].push_back({tlast, tdata});
          mbeat[d] = mbeat[d] + 32'd1;
          if (tlast) mpkt[d] = mpkt[d] + 32'd1;
        end
        mcyc[d]++;
        mlfsr[d] = lfsr_step(mlfsr[d]);
      end
    end
    started = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int d = 0; d < ND; d++) begin
        chk("m_tready", d, 32'(tready[d]), 32'(model_ready(d)));
        chk("m_fill", d, 32'(fill[d]), 32'(mq[d].size()));
        chk("m_rd_valid", d, 32'(rd_valid[d]), 32'(mq[d].size() > 0));
        chk("m_beat_cnt", d, beat[d], mbeat[d]);
        chk("m_pkt_cnt", d, pkt[d], mpkt[d]);
        chk("m_err", d, 32'(err[d]), 32'(merr[d]));
        if (mq[d].size() > 0) begin
          chk("m_rd_data", d, 32'(rd_data[d]), 32'(mq[d][0][7:0]));
          chk("m_rd_last", d, 32'(rd_last[d]), 32'(mq[d][0][8]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    tvalid = v; tdata = d; tlast = l; rd_en = r;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        r;
    logic [4:0]  fill;
    logic [31:0] beat;
    logic [31:0] pkt;
    logic        rv;
    logic [7:0]  rdd;
    logic        rl;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int rdprob;
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 32'd1, 32'd0, 1'b1, 8'h11, 1'b0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 5'd2, 32'd2, 32'd0, 1'b1, 8'h11, 1'b0};
    tbl[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 5'd3, 32'd3, 32'd0, 1'b1, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 5'd4, 32'd4, 32'd0, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b1, 8'h15, 1'b1, 1'b0, 5'd5, 32'd5, 32'd1, 1'b1, 8'h11, 1'b0};
    tbl[5]  = '{1'b0, 8'h15, 1'b1, 1'b1, 5'd4, 32'd5, 32'd1, 1'b1, 8'h12, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd3, 32'd5, 32'd1, 1'b1, 8'h13, 1'b0};
    tbl[7]  = '{1'b1, 8'h16, 1'b0, 1'b1, 5'd3, 32'd6, 32'd1, 1'b1, 8'h14, 1'b0};
    tbl[8]  = '{1'b1, 8'h17, 1'b1, 1'b1, 5'd3, 32'd7, 32'd2, 1'b1, 8'h15, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 32'd7, 32'd2, 1'b1, 8'h16, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 32'd7, 32'd2, 1'b1, 8'h17, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 32'd7, 32'd2, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 32'd7, 32'd2, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b1, 8'h20, 1'b0, 1'b1, 5'd1, 32'd8, 32'd2, 1'b1, 8'h20, 1'b0};

    areset = 1'b1;
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("rst_tready", 0, 32'(tready[0]), 32'd0);
    chk("rst_fill", 0, 32'(fill[0]), 32'd0);
    chk("rst_rd_valid", 0, 32'(rd_valid[0]), 32'd0);
    chk("rst_beat", 0, beat[0], 32'd0);

    // Mode 0 capture, simultaneous push/pop at fill=3, empty-pop and drain.
    areset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
      cyc();
      chk($sformatf("vec%0d_fill", i), 0, 32'(fill[0]), 32'(tbl[i].fill));
      chk($sformatf("vec%0d_beat", i), 0, beat[0], tbl[i].beat);
      chk($sformatf("vec%0d_pkt", i), 0, pkt[0], tbl[i].pkt);
      chk($sformatf("vec%0d_rd_valid", i), 0, 32'(rd_valid[0]), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("vec%0d_rd_data", i), 0, 32'(rd_data[0]), 32'(tbl[i].rdd));
        chk($sformatf("vec%0d_rd_last", i), 0, 32'(rd_last[0]), 32'(tbl[i].rl));
      end
    end

    // Full: 16 beats fill the FIFO, 17th waits until one pop frees a slot.
    areset = 1'b1; drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
    areset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      cyc();
    end
    chk("full_fill", 0, 32'(fill[0]), 32'd16);
    chk("full_tready", 0, 32'(tready[0]), 32'd0);
    drive(1'b1, 8'h40, 1'b0, 1'b0);
    cyc();
    chk("full_hold_beat", 0, beat[0], 32'd16);
    rd_en = 1'b1;
    #1;
    chk("full_pop_tready", 0, 32'(tready[0]), 32'd0);
    cyc();
    rd_en = 1'b0;
    chk("after_pop_fill", 0, 32'(fill[0]), 32'd15);
    chk("after_pop_tready", 0, 32'(tready[0]), 32'd1);
    chk("after_pop_head", 0, 32'(rd_data[0]), 32'h31);
    chk("after_pop_beat", 0, beat[0], 32'd16);
    cyc();
    chk("beat17_fill", 0, 32'(fill[0]), 32'd16);
    chk("beat17_beat", 0, beat[0], 32'd17);

    // Reset mid-operation, then first beat lands at the head.
    areset = 1'b1; drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
    areset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'(8'h50 + i), (i == 6), 1'b0);
      cyc();
    end
    tvalid = 1'b0;
    chk("mid_fill", 0, 32'(fill[0]), 32'd7);
    chk("mid_beat", 0, beat[0], 32'd7);
    areset = 1'b1;
    drive(1'b1, 8'h66, 1'b0, 1'b1);
    #1;
    chk("mid_rst_tready", 0, 32'(tready[0]), 32'd0);
    cyc();
    chk("mid_rst_fill", 0, 32'(fill[0]), 32'd0);
    chk("mid_rst_beat", 0, beat[0], 32'd0);
    chk("mid_rst_pkt", 0, pkt[0], 32'd0);
    chk("mid_rst_rd_valid", 0, 32'(rd_valid[0]), 32'd0);
    areset = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    cyc();
    tvalid = 1'b0;
    chk("post_rst_fill", 0, 32'(fill[0]), 32'd1);
    chk("post_rst_head", 0, 32'(rd_data[0]), 32'h99);

    // Mode 1 periodic ready with tvalid held for 16 cycles.
    areset = 1'b1; drive(1'b0, 8'h00, 1'b0, 1'b0); cyc();
    areset = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("per_tready_c%0d", k), 1, 32'(tready[1]), 32'((k % 4) == 0));
      cyc();
    end
    chk("per_beat", 1, beat[1], 32'd4);
    chk("per_err", 1, 32'(err[1]), 32'd0);

    // Stability violation on mode 1: payload changes while stalled.
    areset = 1'b1; cyc();
    areset = 1'b0; drive(1'b0, 8'h00, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    #1;
    chk("viol_stall_tready", 1, 32'(tready[1]), 32'd0);
    cyc();
    chk("viol_pre_err", 1, 32'(err[1]), 32'd0);
    tdata = 8'h5A;
    cyc();
    chk("viol_err", 1, 32'(err[1]), 32'd1);
    tvalid = 1'b0;
    repeat (5) cyc();
    chk("viol_sticky", 1, 32'(err[1]), 32'd1);
    areset = 1'b1; cyc();
    chk("viol_cleared", 1, 32'(err[1]), 32'd0);
    areset = 1'b0;

    // Randomized traffic, checked by the model every cycle.
    rdprob = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) rdprob = (rdprob == 20) ? 80 : 20;
      areset = ($urandom_range(0, 149) == 0);
      if (!tvalid || $urandom_range(0, 9) < 3) begin
        tvalid = ($urandom_range(0, 3) != 0);
        tdata  = 8'($urandom);
        tlast  = ($urandom_range(0, 4) == 0);
      end else if ($urandom_range(0, 19) == 0) begin
        tvalid = 1'b0;
      end
      rd_en = ($urandom_range(0, 99) < rdprob);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    areset = 1'b0;
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
